bus_xfer_ctrl: RTL and testbench
================================

# bus_xfer_ctrl

Bus master for the shared 4-bit CPU bus. It accepts register-to-register transfer commands and sequences the responder-side strobes for each transfer: one-hot output-enable to the source register, then one-hot load-enable to the destination register. It can also drive an immediate value onto the bus itself. It sits between the control logic and the bank of bus registers, and advances one phase per CPU clock tick (`step`) generated by the clock/timer block.

## Interface
Parameters:
- `NREG`, 4 — number of bus registers controlled. Index `NREG` denotes the controller itself (immediate/none).
- `DW`, 4 — bus width in bits.
- Derived `IW` = `$clog2(NREG+1)` — index width.

Ports:
- `clk`  in  1  — 100 MHz system clock, the only clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `step`  in  1  — single-cycle CPU-clock tick. Qualifies every phase advance.
- `cmd_valid`  in  1  — command offered.
- `cmd_ready`  out  1  — controller can accept a command.
- `cmd_src`  in  IW  — source index. `NREG` means immediate.
- `cmd_dst`  in  IW  — destination index. `NREG` means no load (observe only).
- `cmd_imm`  in  DW  — immediate value, used when `cmd_src==NREG`.
- `bus_in`  in  DW  — resolved bus value, sampled for `last_data`.
- `out_en`  out  NREG  — one-hot source enable (registers drive the bus).
- `load_en`  out  NREG  — one-hot destination load enable.
- `bus_drv_en`  out  1  — controller drives `bus_drv_data` onto the bus.
- `bus_drv_data`  out  DW  — immediate data driven.
- `last_data`  out  DW  — bus value captured at the end of the last LOAD phase.
- `busy`  out  1  — transfer in progress.
- `done`  out  1  — one-cycle pulse when a transfer completes.
- `err`  out  1  — one-cycle reject pulse. Present only with `BUS_XFER_CHECK_EN`.

## Operation
- States: IDLE, DRIVE, LOAD, HOLD. All outputs are registered.
- **IDLE**
  - `cmd_ready=1`, `busy=0`, and all enables are 0.
  - On `cmd_valid&cmd_ready`, latch src/dst/imm and go to DRIVE. A `step` in the accept cycle is ignored.
- **DRIVE**
  - `out_en[src]=1`. If `src==NREG`: `bus_drv_en=1` and `bus_drv_data=imm`.
  - On `step`, go to LOAD.
- **LOAD**
  - Source enables are held.
  - `load_en[dst]=1`. No load bit is set if `dst==NREG`.
  - On `step`, go to HOLD and capture `bus_in` into `last_data`.
- **HOLD**
  - `load_en=0`. Source enables are still held, giving the destination hold time.
  - On `step`, go to IDLE, drop all enables, and pulse `done` for one cycle.
- `busy` = state≠IDLE. `cmd_ready` = (state==IDLE) & `rst_n` released.
- `out_en` and `load_en` are never multi-hot. `bus_drv_en` and any `out_en` bit are never high together.
- Without `BUS_XFER_CHECK_EN`:
  - An index >NREG decodes to no strobe for that field.
  - `src==dst` is legal: the register drives and reloads itself, with no value change.

## Timing
- Reset values: `out_en=0`, `load_en=0`, `bus_drv_en=0`, `bus_drv_data=0`, `last_data=0`, `busy=0`, `done=0`, `err=0`, `cmd_ready=0` while `rst_n=0`. State is IDLE.
- Accept to enables: `out_en`/`bus_drv_en` go high on the clk edge after the accept cycle.
- A transfer takes exactly 3 `step` pulses after accept.
  - `load_en` is high from the 1st step edge to the 2nd step edge.
  - `done` and `cmd_ready` rise on the edge after the 3rd step.
- Back-to-back transfers: a new command may be accepted in the same cycle `done` is high. There is at least 1 idle clk cycle with all enables low between transfers.
- `step` held high for consecutive cycles advances one phase per clk cycle. This is legal, and each phase is then 1 cycle.
- Reset mid-transfer: all enables drop asynchronously, no `done` is issued, `last_data` clears, and the state returns to IDLE.
- `cmd_*` inputs are ignored while `busy`.

## Configuration
- `BUS_XFER_CHECK_EN` defined:
  - At accept, a command is rejected if `src==dst` with `src<NREG`, or if `src>NREG`, or if `dst>NREG`.
  - A rejected command is consumed (handshake completes) and `err` pulses 1 cycle on the next edge.
  - No enables are asserted, no `done` is issued, and the state stays IDLE.
- Undefined: the `err` port is tied to 0, no checking is done, and the behaviour is as in Operation.

## Test plan
- Reset then idle:
  - With `rst_n=0`, all outputs are 0.
  - After release, `cmd_ready=1` and `busy=0`.
- Register move src=1, dst=2, `bus_in`=4'hA:
  - `out_en`=4'b0010 for 3 steps.
  - `load_en`=4'b0100 only between step 1 and step 2.
  - `last_data`=4'hA, and `done` pulses once after step 3.
- Immediate load src=NREG, imm=4'h5, dst=0:
  - `bus_drv_en=1` and `bus_drv_data`=4'h5 through HOLD.
  - `load_en`=4'b0001 during LOAD, and `out_en` stays 0 throughout.
- Reset mid-transfer: assert `rst_n=0` during LOAD.
  - Enables drop in the same cycle (asynchronous).
  - No `done` is issued, `last_data=0`, and `cmd_ready=1` after release.
- Back-to-back: hold `cmd_valid` with two queued commands and `step` tied high.
  - The second accept happens on the `done` cycle.
  - There is exactly one all-low cycle between transfers.
  - `out_en` is never multi-hot.
- With `BUS_XFER_CHECK_EN`, command src=3, dst=3:
  - `err` pulses once, with no enables and no `done`.
  - The following valid command executes normally.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
// Bus master for the shared CPU bus: sequences DRIVE/LOAD/HOLD strobes per transfer on each step.
// Define BUS_XFER_CHECK_EN to reject illegal commands with a one-cycle err pulse.
module bus_xfer_ctrl #(
  parameter int unsigned  NREG = 4,
  parameter int unsigned  DW   = 4,
  localparam int unsigned IW   = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            step,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IW-1:0]   cmd_src,
  input  logic [IW-1:0]   cmd_dst,
  input  logic [DW-1:0]   cmd_imm,
  input  logic [DW-1:0]   bus_in,
  output logic [NREG-1:0] out_en,
  output logic [NREG-1:0] load_en,
  output logic            bus_drv_en,
  output logic [DW-1:0]   bus_drv_data,
  output logic [DW-1:0]   last_data,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {StIdle, StDrive, StLoad, StHold} state_e;

  localparam logic [IW-1:0] SelfIdx = IW'(NREG);

  state_e        state_q;
  logic [IW-1:0] dst_q;
  logic          accept;
  logic          reject;

  // Indices at or above NREG select nothing.
  function automatic logic [NREG-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      v[i] = (idx == IW'(i));
    end
    return v;
  endfunction

  assign accept = (state_q == StIdle) && cmd_valid && cmd_ready;

`ifdef BUS_XFER_CHECK_EN
  assign reject = ((cmd_src == cmd_dst) && (cmd_src < SelfIdx)) ||
                  (cmd_src > SelfIdx) || (cmd_dst > SelfIdx);

  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && reject;
    end
  end
  assign err = err_q;
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      dst_q        <= '0;
      out_en       <= '0;
      load_en      <= '0;
      bus_drv_en   <= 1'b0;
      bus_drv_data <= '0;
      last_data    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cmd_ready    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready <= 1'b1;
          // A step arriving in the accept cycle is deliberately not consumed.
          if (accept && !reject) begin
            state_q      <= StDrive;
            dst_q        <= cmd_dst;
            out_en       <= onehot(cmd_src);
            bus_drv_en   <= (cmd_src == SelfIdx);
            bus_drv_data <= (cmd_src == SelfIdx) ? cmd_imm : '0;
            busy         <= 1'b1;
            cmd_ready    <= 1'b0;
          end
        end
        StDrive: begin
          if (step) begin
            state_q <= StLoad;
            load_en <= onehot(dst_q);
          end
        end
        StLoad: begin
          if (step) begin
            state_q   <= StHold;
            load_en   <= '0;
            last_data <= bus_in;
          end
        end
        StHold: begin
          // Source stays enabled through HOLD so the destination sees stable data.
          if (step) begin
            state_q      <= StIdle;
            out_en       <= '0;
            bus_drv_en   <= 1'b0;
            bus_drv_data <= '0;
            busy         <= 1'b0;
            done         <= 1'b1;
            cmd_ready    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl: a register-bank model predicts each transfer's strobes
// and captured value; a monitor compares the DUT every cycle against the queued prediction.
module tb_bus_xfer_ctrl;

  localparam int unsigned NREG = 4;
  localparam int unsigned DW   = 4;
  localparam int unsigned IW   = 3;

`ifdef BUS_XFER_CHECK_EN
  localparam bit Check = 1'b1;
`else
  localparam bit Check = 1'b0;
`endif

  typedef struct {
    logic [IW-1:0] src;
    logic [IW-1:0] dst;
    logic [DW-1:0] imm;
  } cmd_t;

  typedef struct {
    logic [NREG-1:0] oe;
    logic [NREG-1:0] le;
    logic            drv;
    logic [DW-1:0]   data;
    logic [DW-1:0]   val;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            step;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [IW-1:0]   cmd_src;
  logic [IW-1:0]   cmd_dst;
  logic [DW-1:0]   cmd_imm;
  logic [DW-1:0]   bus_in;
  logic [NREG-1:0] out_en;
  logic [NREG-1:0] load_en;
  logic            bus_drv_en;
  logic [DW-1:0]   bus_drv_data;
  logic [DW-1:0]   last_data;
  logic            busy;
  logic            done;
  logic            err;

  bus_xfer_ctrl #(.NREG(NREG), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .step         (step),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_src      (cmd_src),
    .cmd_dst      (cmd_dst),
    .cmd_imm      (cmd_imm),
    .bus_in       (bus_in),
    .out_en       (out_en),
    .load_en      (load_en),
    .bus_drv_en   (bus_drv_en),
    .bus_drv_data (bus_drv_data),
    .last_data    (last_data),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  cmd_t          cmd_q[$];
  exp_t          exp_q[$];
  logic [DW-1:0] regs_m[NREG];
  logic [DW-1:0] regs_b[NREG];
  logic [DW-1:0] saved[NREG];
  int            step_pct  = 0;
  int            valid_pct = 100;
  int            b2b_hits  = 0;
  bit            pending   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit is_reject(input cmd_t c);
    return Check && (((c.src == c.dst) && (c.src < IW'(NREG))) ||
                     (c.src > IW'(NREG)) || (c.dst > IW'(NREG)));
  endfunction

  // Transaction-level reference: a move copies a value between bank entries.
  task automatic accept_cmd(input cmd_t c);
    exp_t e;
    e.oe   = (c.src < IW'(NREG)) ? (NREG'(1) << c.src) : '0;
    e.le   = (c.dst < IW'(NREG)) ? (NREG'(1) << c.dst) : '0;
    e.drv  = (c.src == IW'(NREG));
    e.data = e.drv ? c.imm : '0;
    e.val  = e.drv ? c.imm : ((c.src < IW'(NREG)) ? regs_m[int'(c.src)] : '0);
    if (c.dst < IW'(NREG)) regs_m[int'(c.dst)] = e.val;
    exp_q.push_back(e);
  endtask

  // Register bank driven purely by the DUT strobes; it reloads from the model while in reset.
  always_comb begin
    bus_in = '0;
    if (bus_drv_en) bus_in = bus_drv_data;
    for (int i = 0; i < NREG; i++) begin
      if (out_en[i]) bus_in = bus_in | regs_b[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (!rst_n) regs_b[i] <= regs_m[i];
      else if (load_en[i]) regs_b[i] <= bus_in;
    end
  end

  // Timing model: transfer lasts three steps after the accept edge.
  bit active, armed, done_exp, err_exp;
  int nsteps;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active = 0; armed = 0; done_exp = 0; err_exp = 0; nsteps = 0;
    end else begin
      done_exp = 0;
      err_exp  = 0;
      if (active) begin
        if (step) begin
          nsteps++;
          if (nsteps == 3) begin
            active   = 0;
            done_exp = 1;
          end
        end
      end else if (armed && cmd_valid) begin
        if (is_reject('{src: cmd_src, dst: cmd_dst, imm: cmd_imm})) err_exp = 1;
        else begin
          active = 1;
          nsteps = 0;
        end
      end
      armed = 1;
    end
  end

  exp_t h;
  exp_t zero_e = '{oe: '0, le: '0, drv: 1'b0, data: '0, val: '0};
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset outputs", 32'({out_en, load_en, bus_drv_en, bus_drv_data, last_data,
                                  busy, done, err, cmd_ready}), 32'd0);
    end else begin
      h = zero_e;
      if (active) begin
        if (exp_q.size() > 0) h = exp_q[0];
        else check("scoreboard empty while busy", 32'(exp_q.size()), 32'd1);
      end
      check("busy", 32'(busy), 32'(active));
      check("cmd_ready", 32'(cmd_ready), 32'(armed && !active));
      check("done", 32'(done), 32'(done_exp));
      check("err", 32'(err), 32'(err_exp));
      check("out_en", 32'(out_en), 32'(h.oe));
      check("bus_drv_en", 32'(bus_drv_en), 32'(h.drv));
      check("bus_drv_data", 32'(bus_drv_data), 32'(h.data));
      check("load_en", 32'(load_en), (active && nsteps == 1) ? 32'(h.le) : 32'd0);
      check("strobe exclusivity", 32'($onehot0(out_en) && $onehot0(load_en) &&
                                       !(bus_drv_en && (|out_en))), 32'd1);
      if (done_exp) begin
        if (exp_q.size() > 0) begin
          check("last_data", 32'(last_data), 32'(exp_q[0].val));
          void'(exp_q.pop_front());
        end else begin
          check("scoreboard empty at done", 32'(exp_q.size()), 32'd1);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    step = ($urandom_range(0, 99) < step_pct);
    if (cmd_q.size() > 0 && (pending || $urandom_range(0, 99) < valid_pct)) begin
      cmd_valid = 1'b1;
      cmd_src   = cmd_q[0].src;
      cmd_dst   = cmd_q[0].dst;
      cmd_imm   = cmd_q[0].imm;
      pending   = 1'b1;
    end else begin
      cmd_valid = 1'b0;
      cmd_src   = IW'($urandom);
      cmd_dst   = IW'($urandom);
      cmd_imm   = DW'($urandom);
    end
    @(negedge clk);
    if (cmd_valid && cmd_ready) begin
      if (done) b2b_hits++;
      if (!is_reject(cmd_q[0])) accept_cmd(cmd_q[0]);
      void'(cmd_q.pop_front());
      pending = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((cmd_q.size() > 0 || busy || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain within budget", 32'(n < budget), 32'd1);
    cycle();
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pcts[3] = '{100, 50, 20};
    cmd_t c;
    rst_n = 1'b0; step = 1'b0; cmd_valid = 1'b0;
    cmd_src = '0; cmd_dst = '0; cmd_imm = '0;
    for (int i = 0; i < NREG; i++) regs_m[i] = DW'($urandom);
    regs_m[1] = 4'hA;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready after reset", 32'(cmd_ready), 32'd1);
    check("idle after reset", 32'(busy), 32'd0);

    // Register move 1 -> 2, then immediate 5 -> 0.
    step_pct = 30;
    cmd_q.push_back('{src: 3'd1, dst: 3'd2, imm: 4'h0});
    drain(200);
    check("move landed in bank", 32'(regs_b[2]), 32'hA);
    cmd_q.push_back('{src: 3'd4, dst: 3'd0, imm: 4'h5});
    drain(200);
    check("immediate landed in bank", 32'(regs_b[0]), 32'h5);

    // Reset while in LOAD.
    saved = regs_m;
    step_pct = 0;
    cmd_q.push_back('{src: 3'd1, dst: 3'd3, imm: 4'h0});
    n = 0;
    while (cmd_q.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    check("reset-test accept", 32'(cmd_q.size()), 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
    check("load_en in LOAD", 32'(load_en), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    check("async strobe drop", 32'({out_en, load_en, bus_drv_en, busy, done}), 32'd0);
    exp_q.delete();
    regs_m = saved;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready after mid reset", 32'(cmd_ready), 32'd1);
    check("last_data cleared", 32'(last_data), 32'd0);
    check("reg3 untouched", 32'(regs_b[3]), 32'(saved[3]));

    // Back-to-back with step tied high.
    step_pct = 100;
    b2b_hits = 0;
    cmd_q.push_back('{src: 3'd0, dst: 3'd1, imm: 4'h0});
    cmd_q.push_back('{src: 3'd2, dst: 3'd3, imm: 4'h0});
    drain(100);
    check("second accept on done cycle", 32'(b2b_hits), 32'd1);

`ifdef BUS_XFER_CHECK_EN
    step_pct = 50;
    cmd_q.push_back('{src: 3'd3, dst: 3'd3, imm: 4'h0});
    cmd_q.push_back('{src: 3'd3, dst: 3'd1, imm: 4'h0});
    drain(200);
`endif

    // Randomized traffic with varying step density and gaps.
    for (int b = 0; b < 6; b++) begin
      step_pct  = pcts[b % 3];
      valid_pct = 60;
      for (int k = 0; k < 50; k++) begin
        c.src = IW'($urandom_range(0, 7));
        c.dst = IW'($urandom_range(0, 7));
        c.imm = DW'($urandom);
        cmd_q.push_back(c);
      end
      drain(4000);
    end
    for (int i = 0; i < NREG; i++) check("final bank vs model", 32'(regs_b[i]), 32'(regs_m[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
